// File: rtl/tdm_demux4.sv
// ============================================================================
// Module      : tdm_demux4
// Description : Receive side of the 4-lane TDM link. It de-serialises slot
//               words into four parallel lanes and strobes each complete frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked,
    output logic [1:0]       slot
);

    localparam logic [0:0] c_ST_HUNT   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;
    logic [WIDTH-1:0] r_y0, r_y1, r_y2, r_y3;
    logic             r_frame_valid;
    logic             r_sync_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_HUNT;
            r_slot        <= 2'd0;
            r_sh0         <= '0;
            r_sh1         <= '0;
            r_sh2         <= '0;
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    c_ST_HUNT: begin
                        // Words are ignored until a start-of-frame re-establishes alignment.
                        if (in_sof) begin
                            r_sh0   <= in_data;
                            r_slot  <= 2'd1;
                            r_state <= c_ST_LOCKED;
                        end
                    end
                    default: begin
                        if (in_sof) begin
                            // A SOF that arrives mid-frame discards the partial frame and starts a new frame at slot 0.
                            r_sync_err <= (r_slot != 2'd0);
                            r_sh0      <= in_data;
                            r_slot     <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd0: begin
                                    r_sync_err <= 1'b1;
                                    r_state    <= c_ST_HUNT;
                                end
                                2'd1: begin
                                    r_sh1  <= in_data;
                                    r_slot <= 2'd2;
                                end
                                2'd2: begin
                                    r_sh2  <= in_data;
                                    r_slot <= 2'd3;
                                end
                                default: begin
                                    r_y0          <= r_sh0;
                                    r_y1          <= r_sh1;
                                    r_y2          <= r_sh2;
                                    r_y3          <= in_data;
                                    r_frame_valid <= 1'b1;
                                    r_slot        <= 2'd0;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign y0          = r_y0;
    assign y1          = r_y1;
    assign y2          = r_y2;
    assign y3          = r_y3;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == c_ST_LOCKED);
    assign slot        = r_slot;

endmodule

`default_nettype wire
